// File: rtl/fpu_vec_pkg.sv
// Shared types for the FPU vector checker: FSM states, control bundle and the
// 274-bit stored vector layout.
package fpu_vec_pkg;

  localparam int FP_W   = 64;
  localparam int FLAG_W = 5;
  localparam int CTRL_W = 6;
  localparam int MASK_W = 2;
  localparam int VEC_W  = 2*FP_W + CTRL_W + MASK_W + 2*(FP_W + FLAG_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_APPLY,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } vec_state_t;

  typedef struct packed {
    logic       db;
    logic       normal;
    logic       sub;
    logic       fdiv;
    logic [1:0] rm;
  } fpu_ctrl_t;

  // mask[1] enables the mul check, mask[0] the add check
  typedef struct packed {
    logic [FP_W-1:0]   fpa;
    logic [FP_W-1:0]   fpb;
    fpu_ctrl_t         ctrl;
    logic [MASK_W-1:0] mask;
    logic [FP_W-1:0]   exp_mul;
    logic [FLAG_W-1:0] exp_iee_mul;
    logic [FP_W-1:0]   exp_add;
    logic [FLAG_W-1:0] exp_iee_add;
  } fpu_vec_t;

  // A disabled check always passes; an enabled one needs result and flags exact.
  function automatic logic field_ok(input logic                    en,
                                    input logic [FP_W+FLAG_W-1:0] got,
                                    input logic [FP_W+FLAG_W-1:0] exp);
    return !en || (got == exp);
  endfunction

endpackage

// File: rtl/fpu_vec_checker_if.sv
// Operand/result bus between the vector checker and the FPU top level.
interface fpu_vec_checker_if;
  import fpu_vec_pkg::*;

  logic [FP_W-1:0]   fpa;
  logic [FP_W-1:0]   fpb;
  logic              db;
  logic              normal;
  logic              sub;
  logic              fdiv;
  logic [1:0]        RM;
  logic [FP_W-1:0]   fp_mul_out;
  logic [FLAG_W-1:0] IEEp_mul;
  logic [FP_W-1:0]   fp_add_out;
  logic [FLAG_W-1:0] IEEp_add;

  modport master (
    output fpa, fpb, db, normal, sub, fdiv, RM,
    input  fp_mul_out, IEEp_mul, fp_add_out, IEEp_add
  );

  modport slave (
    input  fpa, fpb, db, normal, sub, fdiv, RM,
    output fp_mul_out, IEEp_mul, fp_add_out, IEEp_add
  );

endinterface

// File: rtl/fpu_vec_ram.sv
// Vector table: one write port, one registered read port that holds its data
// while re is low, so the read register doubles as the operand hold register.
module fpu_vec_ram
  import fpu_vec_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  fpu_vec_t          wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output fpu_vec_t          rdata
);

  fpu_vec_t mem [DEPTH];

  // NOTE: the array has no reset on purpose -- contents must survive rst, and a
  // reset would also stop it mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fpu_vec_checker.sv
// Plays stored vectors into the FPU, waits SETTLE cycles, compares results
// against the expected values and keeps saturating pass/fail statistics.
module fpu_vec_checker
  import fpu_vec_pkg::*;
#(
  parameter  int DEPTH  = 64,
  parameter  int SETTLE = 4,
  parameter  int CNT_W  = 16,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ld_we,
  input  logic [ADDR_W-1:0]   ld_addr,
  input  logic [VEC_W-1:0]    ld_vec,
  input  logic [ADDR_W:0]     num_vec,
  input  logic                start,
  fpu_vec_checker_if.master   bus,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    pass_cnt,
  output logic [CNT_W-1:0]    fail_cnt,
  output logic                first_fail_vld,
  output logic [ADDR_W-1:0]   first_fail_idx,
  output logic                fail_pulse
);

  localparam int              SET_W       = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);
  localparam logic [ADDR_W:0] DEPTH_C     = (ADDR_W + 1)'(DEPTH);

  vec_state_t        state_q, state_d;
  logic [ADDR_W:0]   idx_q, idx_nxt;
  logic [ADDR_W:0]   num_q, num_eff;
  logic [SET_W-1:0]  set_q;
  fpu_vec_t          rd_vec;
  logic              idle_or_done, start_ok, last_vec;
  logic              mul_ok, add_ok, vec_pass;

  assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
  assign start_ok     = start && idle_or_done;
  assign busy         = !idle_or_done;
  assign done         = (state_q == S_DONE);
  assign num_eff      = (num_vec > DEPTH_C) ? DEPTH_C : num_vec;
  assign idx_nxt      = idx_q + (ADDR_W + 1)'(1);
  assign last_vec     = (idx_nxt >= num_q);

  fpu_vec_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ld_we && idle_or_done && ({1'b0, ld_addr} < DEPTH_C)),
    .waddr (ld_addr),
    .wdata (fpu_vec_t'(ld_vec)),
    .re    (state_q == S_FETCH),
    .raddr (idx_q[ADDR_W-1:0]),
    .rdata (rd_vec)
  );

  // Read data is only refreshed in FETCH, so operands stay put from APPLY on.
  assign bus.fpa    = rd_vec.fpa;
  assign bus.fpb    = rd_vec.fpb;
  assign bus.db     = rd_vec.ctrl.db;
  assign bus.normal = rd_vec.ctrl.normal;
  assign bus.sub    = rd_vec.ctrl.sub;
  assign bus.fdiv   = rd_vec.ctrl.fdiv;
  assign bus.RM     = rd_vec.ctrl.rm;

  assign mul_ok   = field_ok(rd_vec.mask[1], {bus.fp_mul_out, bus.IEEp_mul},
                             {rd_vec.exp_mul, rd_vec.exp_iee_mul});
  assign add_ok   = field_ok(rd_vec.mask[0], {bus.fp_add_out, bus.IEEp_add},
                             {rd_vec.exp_add, rd_vec.exp_iee_add});
  assign vec_pass = mul_ok && add_ok;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (start) state_d = (num_eff == '0) ? S_DONE : S_FETCH;
      S_FETCH:        state_d = S_APPLY;
      S_APPLY:        state_d = S_SETTLE;
      S_SETTLE:       if (set_q == '0) state_d = S_CHECK;
      S_CHECK:        state_d = last_vec ? S_DONE : S_FETCH;
      default:        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q          <= '0;
      num_q          <= '0;
      set_q          <= '0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_vld <= 1'b0;
      first_fail_idx <= '0;
      fail_pulse     <= 1'b0;
    end else begin
      fail_pulse <= 1'b0;

      if (start_ok) begin
        idx_q          <= '0;
        num_q          <= num_eff;
        pass_cnt       <= '0;
        fail_cnt       <= '0;
        first_fail_vld <= 1'b0;
      end

      if (state_q == S_APPLY)                      set_q <= SETTLE_LAST;
      else if (state_q == S_SETTLE && set_q != '0) set_q <= set_q - SET_W'(1);

      if (state_q == S_CHECK) begin
        idx_q <= idx_nxt;
        if (vec_pass) begin
          if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
        end else begin
          if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
          fail_pulse <= 1'b1;
          if (!first_fail_vld) begin
            first_fail_vld <= 1'b1;
            first_fail_idx <= idx_q[ADDR_W-1:0];
          end
        end
      end
    end
  end

endmodule

// File: doc/fpu_vec_checker.md
# fpu_vec_checker

Synthesizable, self-checking vector engine for the FPU top level (`master`). It holds a parametrised table of operand/control/expected-result vectors and plays them into `master` one at a time. After a programmable settle interval it compares the multiply/divide and add results and flags against the expected values. It accumulates pass/fail statistics, so the regression suite can run on an FPGA or in a clocked bench without a file-reading testbench.

## Interface
Parameters:
- `DEPTH`, 64: number of vector slots, ≥1.
- `SETTLE`, 4: wait cycles between driving a vector and sampling results, ≥1.
- `CNT_W`, 16: width of the pass/fail counters.
- `ADDR_W`, `$clog2(DEPTH)`: derived, not overridden.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `ld_we` in 1: write one vector slot (honoured only in IDLE/DONE).
- `ld_addr` in ADDR_W: slot index to write.
- `ld_vec` in 274: `{fpa[63:0], fpb[63:0], ctrl[5:0], mask[1:0], exp_mul[63:0], exp_iee_mul[4:0], exp_add[63:0], exp_iee_add[4:0]}`.
  - `ctrl` = `{db, normal, sub, fdiv, RM[1:0]}`.
  - `mask[1]` enables the mul check; `mask[0]` enables the add check.
- `num_vec` in ADDR_W+1: number of vectors to run, 0..DEPTH, sampled on `start`.
- `start` in 1: begin a run (honoured only in IDLE/DONE).
- `fpa`, `fpb` out 64: operands to `master`.
- `db`, `normal`, `sub`, `fdiv` out 1 each: controls to `master`.
- `RM` out 2: rounding mode to `master`.
- `fp_mul_out` in 64, `IEEp_mul` in 5: results from `master`.
- `fp_add_out` in 64, `IEEp_add` in 5: results from `master`.
- `busy` out 1: a run is in progress.
- `done` out 1: the run has finished.
- `pass_cnt` out CNT_W, `fail_cnt` out CNT_W: statistics.
- `first_fail_vld` out 1, `first_fail_idx` out ADDR_W: first mismatching vector.
- `fail_pulse` out 1: one-cycle strobe on each failing check.

## Operation
- States:
  - IDLE → FETCH on `start`.
  - FETCH: registered RAM read of slot `idx`.
  - APPLY: drive the operand outputs from the read data.
  - SETTLE: count `SETTLE` cycles.
  - CHECK: compare and update the counters.
  - After CHECK: go to FETCH if `idx+1 < num_vec`, otherwise to DONE.
  - DONE → FETCH on `start`; otherwise hold.
- `start` when `num_vec`=0: go straight to DONE with counters cleared.
- `start` from IDLE or DONE clears `pass_cnt`, `fail_cnt`, `first_fail_vld` and `idx`, and latches `num_vec`.
  - `num_vec` > DEPTH is clamped to DEPTH.
- `start`, `ld_we` while `busy`: ignored.
- Operand outputs are held constant from APPLY through CHECK. In IDLE/DONE they hold their last driven value.
- Checking in CHECK:
  - Mul check passes when `{fp_mul_out, IEEp_mul}` == `{exp_mul, exp_iee_mul}`, or when `mask[1]`=0.
  - Add check passes likewise under `mask[0]`.
  - Vector passes when both checks pass; `pass_cnt` increments.
  - Otherwise `fail_cnt` increments and `fail_pulse`=1.
  - If `first_fail_vld`=0, latch `first_fail_idx` and set `first_fail_vld`.
  - `mask`=00 always counts as a pass.
- Comparison is a full 64-bit compare for both `db` values. Single-precision vectors carry duplicated halves in the expected value.
- Counters saturate at 2^CNT_W−1; they never wrap.
- `rst` in any state returns to IDLE on the next edge; vector RAM contents are kept.

## Timing
- Reset values:
  - `fpa`, `fpb` = 0; `db`, `normal`, `sub`, `fdiv` = 0; `RM` = 0.
  - `busy`, `done`, `fail_pulse` = 0; counters = 0; `first_fail_vld` = 0, `first_fail_idx` = 0.
- Per vector: 1 (FETCH) + 1 (APPLY) + SETTLE + 1 (CHECK) = SETTLE+3 cycles.
- With `start` sampled high at edge t:
  - `busy`=1 from t+1.
  - `done`=1 and `busy`=0 from t + N·(SETTLE+3) + 1.
  - For `num_vec`=0: `done`=1 at t+1.
- Counter updates and `fail_pulse` are registered and become visible the cycle after CHECK.
- A `ld_we` write is visible to a FETCH starting on the next cycle. Write and `start` in the same cycle are both honoured; the write lands first.
- `done` stays high until the next honoured `start` or `rst`.

## Structure
- Package `fpu_vec_pkg`:
  - state enum `vec_state_t`.
  - packed struct `fpu_ctrl_t` `{db, normal, sub, fdiv, RM}`.
  - packed struct `fpu_vec_t` (274 b) plus field-width constants.
- Sub-module `fpu_vec_ram`: DEPTH × 274-bit, one write port, one registered read port.
- Top `fpu_vec_checker`: FSM, settle counter, index counter, comparators, statistics.

## Test plan
- Slot 0 = 3.0, 3.0 (`0x4008000000000000`), ctrl db=1, normal=1, RM=00, mask=11, expected `0x4022000000000000` / `0x4018000000000000`, flags 0; `num_vec`=1, SETTLE=4 → `done` at t+8, `pass_cnt`=1, `fail_cnt`=0.
- Slots 0–1 = {3.0×3.0, 4.0+4.0}, with slot 1 `exp_add` corrupted to `0x4020000000000001` → `pass_cnt`=1, `fail_cnt`=1, `first_fail_idx`=1, exactly one `fail_pulse`.
- Same corrupt vector with `mask`=10 → pass; with `mask`=00 → pass.
- `num_vec`=0 → `done` at t+1, both counters 0; `start` during `busy` → no restart, end cycle unchanged.
- `rst` asserted mid-SETTLE of vector 2 → all outputs at reset values next cycle; a new `start` reruns from slot 0 with the RAM intact.
- CNT_W=2, 5 passing vectors → `pass_cnt` saturates at 3.
